// File: rtl/q15_conv_arbiter.sv
// rtl/q15_conv_arbiter.sv - round-robin shared X32-to-Q15 converter, one registered stage.
// Optional Q15_CONV_SAT_COUNT_EN adds a saturating count of overflowed output transfers.
module q15_conv_arbiter #(
    parameter int NREQ  = 2,
    parameter int SRC_W = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_sign_mask,
    input  logic [32*NREQ-1:0]   req_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic [SRC_W-1:0]     out_src,
    output logic                 out_overflow
`ifdef Q15_CONV_SAT_COUNT_EN
    ,
    output logic [15:0]          sat_count
`endif
);

    typedef struct packed {
        logic [63:0] data;
        logic        overflow;
    } conv_t;

    // Magnitudes of 2**15 and above cannot be represented, including -32768.
    function automatic conv_t q15_convert(input logic [31:0] x, input logic m);
        conv_t       r;
        logic        sign;
        logic [31:0] mag;
        logic [15:0] lo;
        sign = m & x[31];
        mag  = sign ? (~x + 32'd1) : x;
        lo   = sign ? (~mag[15:0] + 16'd1) : mag[15:0];
        r.overflow = |mag[31:15];
        if (r.overflow) begin
            r.data = sign ? 64'h8000_0000_0000_0001 : 64'h7fff_ffff_ffff_ffff;
        end else begin
            r.data = {lo, 48'd0};
        end
        return r;
    endfunction

    logic               out_valid_d,    out_valid_q;
    logic [63:0]        out_data_d,     out_data_q;
    logic [SRC_W-1:0]   out_src_d,      out_src_q;
    logic               out_overflow_d, out_overflow_q;
    logic [SRC_W-1:0]   rr_ptr_d,       rr_ptr_q;

    logic               can_accept;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [31:0]        sel_data;
    logic               sel_mask;
    conv_t              conv;
    int                 idx;

    always_comb begin
        can_accept  = !out_valid_q || out_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        sel_data    = '0;
        sel_mask    = 1'b0;
        req_ready   = '0;
        idx         = 0;
        if (can_accept && !reset) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!grant_valid && req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx[SRC_W-1:0];
                    sel_data    = req_data[32*idx +: 32];
                    sel_mask    = req_sign_mask[idx];
                end
            end
        end
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        conv           = q15_convert(sel_data, sel_mask);
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_src_d      = out_src_q;
        out_overflow_d = out_overflow_q;
        rr_ptr_d       = rr_ptr_q;
        if (grant_valid) begin
            out_valid_d    = 1'b1;
            out_data_d     = conv.data;
            out_src_d      = grant_idx;
            out_overflow_d = conv.overflow;
            rr_ptr_d       = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            // Drain leaves the stale payload in place; it is ignored while invalid.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_src_q      <= '0;
            out_overflow_q <= 1'b0;
            rr_ptr_q       <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_src_q      <= out_src_d;
            out_overflow_q <= out_overflow_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_src      = out_src_q;
    assign out_overflow = out_overflow_q;

`ifdef Q15_CONV_SAT_COUNT_EN
    logic [15:0] sat_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count_q <= '0;
        end else if (out_valid_q && out_ready && out_overflow_q && (sat_count_q != 16'hffff)) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_q15_conv_arbiter.sv
// tb/tb_q15_conv_arbiter.sv - directed-vector bench for q15_conv_arbiter.
module tb_q15_conv_arbiter;

    localparam int NREQ  = 2;
    localparam int SRC_W = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_sign_mask;
    logic [32*NREQ-1:0]   req_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_data;
    logic [SRC_W-1:0]     out_src;
    logic                 out_overflow;
`ifdef Q15_CONV_SAT_COUNT_EN
    logic [15:0]          sat_count;
`endif

    always #5 clk = ~clk;

    q15_conv_arbiter #(.NREQ(NREQ), .SRC_W(SRC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sign_mask (req_sign_mask),
        .req_data      (req_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_overflow  (out_overflow)
`ifdef Q15_CONV_SAT_COUNT_EN
        ,
        .sat_count     (sat_count)
`endif
    );

    typedef struct {
        logic        m;
        logic [31:0] x;
        int          src;
        logic [63:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] exp_rdy;

        vecs[0] = '{1'b1, 32'h0000_0003, 0, 64'h0003_0000_0000_0000, 1'b0};
        vecs[1] = '{1'b1, 32'hffff_fffe, 1, 64'hfffe_0000_0000_0000, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_8000, 0, 64'h7fff_ffff_ffff_ffff, 1'b1};
        vecs[3] = '{1'b1, 32'h8000_0000, 1, 64'h8000_0000_0000_0001, 1'b1};
        vecs[4] = '{1'b0, 32'hffff_fffe, 0, 64'h7fff_ffff_ffff_ffff, 1'b1};
        vecs[5] = '{1'b1, 32'hffff_8000, 1, 64'h8000_0000_0000_0001, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_7fff, 0, 64'h7fff_0000_0000_0000, 1'b0};
        vecs[7] = '{1'b1, 32'hffff_8001, 1, 64'h8001_0000_0000_0000, 1'b0};
        vecs[8] = '{1'b0, 32'h0000_0000, 0, 64'h0000_0000_0000_0000, 1'b0};
        vecs[9] = '{1'b1, 32'h0001_0000, 1, 64'h7fff_ffff_ffff_ffff, 1'b1};

        reset         = 1'b1;
        req_valid     = '1;
        req_sign_mask = '0;
        req_data      = '0;
        out_ready     = 1'b1;
        step();
        step();
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_out_src", 64'(out_src), 64'd0);
        check("reset_out_ovf", 64'(out_overflow), 64'd0);
`ifdef Q15_CONV_SAT_COUNT_EN
        check("reset_sat_count", 64'(sat_count), 64'd0);
`endif
        req_valid = '0;
        reset     = 1'b0;
        step();

        // Conversion table, alternating the single active requester.
        for (int i = 0; i < 10; i++) begin
            req_valid = '0;
            req_valid[vecs[i].src] = 1'b1;
            req_sign_mask[vecs[i].src] = vecs[i].m;
            req_data[32*vecs[i].src +: 32] = vecs[i].x;
            exp_rdy = '0;
            exp_rdy[vecs[i].src] = 1'b1;
            #1;
            check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(exp_rdy));
            step();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_out_src", i), 64'(out_src), 64'(vecs[i].src));
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d_out_ovf", i), 64'(out_overflow), 64'(vecs[i].exp_ovf));
        end
        req_valid = '0;
        step();
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Fresh pointer, then both requesters held: strict alternation, no bubbles.
        reset = 1'b1;
        step();
        reset         = 1'b0;
        req_sign_mask = '0;
        req_data      = {32'h0000_0002, 32'h0000_0001};
        req_valid     = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr%0d_req_ready", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            step();
            check($sformatf("rr%0d_out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("rr%0d_out_src", k), 64'(out_src), 64'(k % 2));
            check($sformatf("rr%0d_out_data", k), out_data,
                  (k % 2 == 0) ? 64'h0001_0000_0000_0000 : 64'h0002_0000_0000_0000);
        end

        // Backpressure with requester 1 result pending.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'd0);
            step();
            check($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_out_src", k), 64'(out_src), 64'd1);
            check($sformatf("bp%0d_out_data", k), out_data, 64'h0002_0000_0000_0000);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_req_ready", 64'(req_ready), 64'd1);
        step();
        check("bp_release_out_src", 64'(out_src), 64'd0);
        check("bp_release_out_data", out_data, 64'h0001_0000_0000_0000);

        // Reset mid-stream: pointer now 1, must return to 0.
        reset = 1'b1;
        step();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
`ifdef Q15_CONV_SAT_COUNT_EN
        check("midrst_sat_count", 64'(sat_count), 64'd0);
`endif
        reset = 1'b0;
        #1;
        check("postrst_req_ready", 64'(req_ready), 64'd1);
        step();
        check("postrst_out_src", 64'(out_src), 64'd0);
        check("postrst_out_valid", 64'(out_valid), 64'd1);

        // Two saturated results consumed back to back.
        req_valid     = 2'b01;
        req_sign_mask = 2'b01;
        req_data      = {32'h0000_0000, 32'h8000_0000};
        step();
        check("sat1_out_data", out_data, 64'h8000_0000_0000_0001);
        step();
        check("sat2_out_ovf", 64'(out_overflow), 64'd1);
        req_valid = '0;
        step();
        check("sat_drain_out_valid", 64'(out_valid), 64'd0);
`ifdef Q15_CONV_SAT_COUNT_EN
        check("sat_count_two", 64'(sat_count), 64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/q15_conv_arbiter.md
Name: q15_conv_arbiter

Overview:
- Shares one X32-to-Q15 conversion datapath between NREQ requesters, e.g. the ray-setup and shading stages, which both turn integer register values into Q15 fixed point.
- Round-robin arbitration with valid/ready handshakes on every requester and on the single output.
- One registered conversion stage: 1-cycle latency, 1 result/cycle sustained.
- Sits between the integer register file and the fixed-point ray pipeline.

Parameters:
NREQ, 2, number of requesters; legal 2..4.
SRC_W, 1, width of source index; 2**SRC_W >= NREQ.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
req_sign_mask  input  NREQ  per-requester signed-interpretation flag
req_data  input  32*NREQ  per-requester x32 operand; requester i in bits [32*i+31:32*i]
out_valid  output  1  converted result held in output register
out_ready  input  1  downstream accepts result
out_data  output  64  Q15 result, 64-bit
out_src  output  SRC_W  index of requester that produced out_data
out_overflow  output  1  result was saturated

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=0, out_overflow=0, rr_ptr=0. req_ready is combinational and is 0 during reset.
- can_accept = !out_valid | out_ready.
- Grant: when can_accept, search requesters i = rr_ptr, rr_ptr+1, ... mod NREQ. Grant the first i with req_valid[i]=1 and drive req_ready[i]=1; all other req_ready bits are 0.
- When !can_accept, req_ready is all 0.
- req_ready depends on out_ready combinationally. This is allowed; no combinational path from req_valid to out_*.
- Transfer: req_valid[i] & req_ready[i] in cycle t -> out_valid=1 at t+1, with out_src=i, out_data and out_overflow from the conversion below. Latency is exactly 1 cycle.
- Round-robin pointer: after a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds.
- Hold: while out_valid & !out_ready, out_data, out_src and out_overflow are stable.
- Simultaneous consume and refill: out_ready=1 and a new grant in the same cycle -> the register reloads; out_valid stays 1 with no bubble.
- Drain: out_ready=1 and no grant -> out_valid <= 0. out_data keeps its old value; it is don't-care while out_valid=0.
- Conversion arithmetic, on the granted operand x with mask m:
  - sign = m & x[31]
  - mag = sign ? -x : x, a 32-bit two's complement negate
  - overflow = (mag[31:15] != 0)
  - if overflow: out_data = sign ? 64'h8000000000000001 : 64'h7fffffffffffffff
  - else: out_data = {sign ? -mag[15:0] : mag[15:0], 48'b0}, the negate taken in 16 bits
  - out_overflow = overflow
- Boundary: x=32'h80000000 with m=1 -> mag = 32'h80000000 -> overflow with sign=1 -> out_data=64'h8000000000000001.
- Boundary: x=32'hffff8000 with m=1 -> mag=32'h8000 -> overflow (bit 15 set) -> negative saturate.
- Boundary: with m=0, x[31]=1 is always an overflow -> positive saturate.
- Requesters must hold req_valid and req_data stable until accepted. A dropped request is not an error; the block simply never grants it.
- Reset mid-operation: any pending result is discarded, out_valid=0 next cycle, rr_ptr=0. Requests that were granted but not consumed are lost.

Optional Feature:
- Macro Q15_CONV_SAT_COUNT_EN.
- Defined: adds output port sat_count [15:0].
  - Increments by 1 on each output transfer (out_valid & out_ready) with out_overflow=1.
  - Saturates at 16'hffff; no wrap.
  - Cleared to 0 by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Single requester 0, m=1, x=32'h00000003, out_ready=1 -> out_valid next cycle, out_data=64'h0003000000000000, out_src=0, out_overflow=0.
2. Signed values, m=1:
   - x=32'hfffffffe -> out_data=64'hfffe000000000000, overflow=0.
   - x=32'h00008000 -> 64'h7fffffffffffffff, overflow=1.
   - x=32'h80000000 -> 64'h8000000000000001, overflow=1.
3. Unsigned, m=0, x=32'hfffffffe -> 64'h7fffffffffffffff, overflow=1. Same x with m=1 -> 64'hfffe000000000000.
4. NREQ=2, both req_valid held high for 6 cycles, out_ready=1 -> grants alternate 0,1,0,1,0,1; out_valid continuously 1 from cycle 1; no bubbles.
5. Backpressure: out_ready=0 for 3 cycles with result pending -> req_ready=0, out_data/out_src stable. out_ready=1 -> next grant goes to the requester after the last one granted.
6. Assert reset while out_valid=1 and both requesting -> next cycle out_valid=0, rr_ptr=0. After release, first grant is requester 0. With Q15_CONV_SAT_COUNT_EN: sat_count=0 after reset, and =2 after two saturated transfers.
